// File: rtl/axi_wr_rr_arbiter.sv
// N-master to 1-slave AXI4 write-path arbiter: round-robin AW, W routed in
// AW-acceptance order through an index FIFO, B routed back by ID prefix.
module axi_wr_rr_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int W_FIFO_DEPTH = 4,
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SID_W = ID_WIDTH + IDX_W,
    localparam int AW_W  = ADDR_WIDTH + 13,
    localparam int W_W   = DATA_WIDTH + DATA_WIDTH / 8 + 1,
    localparam int MAW   = ID_WIDTH + AW_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_MASTERS*MAW-1:0] m_aw_pld,
    input  logic [NUM_MASTERS-1:0]     m_awvalid,
    output logic [NUM_MASTERS-1:0]     m_awready,
    input  logic [NUM_MASTERS*W_W-1:0] m_w_pld,
    input  logic [NUM_MASTERS-1:0]     m_wvalid,
    output logic [NUM_MASTERS-1:0]     m_wready,
    output logic [ID_WIDTH+1:0]        m_b_pld,
    output logic [NUM_MASTERS-1:0]     m_bvalid,
    input  logic [NUM_MASTERS-1:0]     m_bready,
    output logic [SID_W+AW_W-1:0]      s_aw_pld,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [W_W-1:0]             s_w_pld,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    input  logic [SID_W+1:0]           s_b_pld,
    input  logic                       s_bvalid,
    output logic                       s_bready
);

    localparam int PTR_W = $clog2(W_FIFO_DEPTH);

    typedef enum logic {IDLE, ISSUE} aw_state_t;

    aw_state_t        state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [IDX_W-1:0] pick;
    logic             found;

    logic [IDX_W-1:0] fifo_mem [W_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [IDX_W-1:0] head;
    logic [W_W-1:0]   head_w;
    logic             head_wvalid;

    logic [IDX_W-1:0] b_idx;
    logic [31:0]      b_idx_ext;

    // First requester at or above the pointer, else lowest requester (wrap).
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && m_awvalid[i] && i >= int'(rr_ptr)) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && m_awvalid[i]) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            sel    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            sel    <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (found && !fifo_full) begin
                    sel_nxt   = pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (s_awready) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (int'(sel) == NUM_MASTERS - 1) ? '0 : sel + 1'b1;
                end
            end
        endcase
    end

    assign s_awvalid = (state == ISSUE);
    assign s_aw_pld  = {sel, m_aw_pld[int'(sel)*MAW +: MAW]};
    assign push      = s_awvalid && s_awready;

    always_comb begin
        m_awready = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_awready[i] = s_awvalid && (int'(sel) == i) && s_awready;
        end
    end

    // Index FIFO: one entry per accepted AW, retired on the burst's WLAST.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_w     = m_w_pld[int'(head)*W_W +: W_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < W_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= sel;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        head_wvalid = 1'b0;
        m_wready    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (int'(head) == i) begin
                head_wvalid = m_wvalid[i];
                m_wready[i] = !fifo_empty && s_wready;
            end
        end
    end

    assign s_w_pld  = head_w;
    assign s_wvalid = !fifo_empty && head_wvalid;
    assign pop      = s_wvalid && s_wready && head_w[0];

    // B path is combinational; gated by reset so no response leaks out.
    assign b_idx     = s_b_pld[SID_W+1 -: IDX_W];
    assign b_idx_ext = 32'(b_idx);
    assign m_b_pld   = s_b_pld[ID_WIDTH+1:0];

    always_comb begin
        m_bvalid = '0;
        s_bready = 1'b0;
        if (rst_n) begin
            s_bready = 1'b1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (b_idx_ext == i) begin
                    m_bvalid[i] = s_bvalid;
                    s_bready    = m_bready[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Testbench for axi_wr_rr_arbiter: scoreboarded AW/W ordering, FIFO-full
// blocking, AW stall, B routing and reset mid-burst.
module tb_axi_wr_rr_arbiter;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int SID_W = IW + IDX_W;
    localparam int AWW   = AW + 13;
    localparam int WW    = DW + DW / 8 + 1;
    localparam int MAW   = IW + AWW;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N*MAW-1:0]       m_aw_pld;
    logic [N-1:0]           m_awvalid, m_awready;
    logic [N*WW-1:0]        m_w_pld;
    logic [N-1:0]           m_wvalid, m_wready;
    logic [IW+1:0]          m_b_pld;
    logic [N-1:0]           m_bvalid, m_bready;
    logic [SID_W+AWW-1:0]   s_aw_pld;
    logic                   s_awvalid, s_awready;
    logic [WW-1:0]          s_w_pld;
    logic                   s_wvalid, s_wready;
    logic [SID_W+1:0]       s_b_pld;
    logic                   s_bvalid, s_bready;

    int total = 0;
    int bad   = 0;
    int w_hs  = 0;

    logic [SID_W+AWW-1:0] exp_aw [$];
    logic [WW-1:0]        exp_w  [$];
    logic [SID_W+AWW-1:0] e_aw;
    logic [WW-1:0]        e_w;

    always #5 clk = ~clk;

    axi_wr_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IW),
        .W_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_aw_pld (m_aw_pld),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_w_pld  (m_w_pld),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_b_pld  (m_b_pld),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .s_aw_pld (s_aw_pld),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_w_pld  (s_w_pld),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_b_pld  (s_b_pld),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready)
    );

    function automatic logic [MAW-1:0] mk_aw(input int m, input logic [7:0] len);
        return {IW'(m + 5), 32'h1000_0000 + 32'(m * 256), len, 3'd2, 2'b01};
    endfunction

    function automatic logic [WW-1:0] mk_w(input int m, input int beat, input logic last);
        return {32'hD000_0000 | 32'(m * 256 + beat), 4'hF, last};
    endfunction

    function automatic void push_aw(input int m, input logic [7:0] len);
        exp_aw.push_back({IDX_W'(m), mk_aw(m, len)});
    endfunction

    function automatic void push_w(input int m, input int beats);
        for (int b = 0; b < beats; b++) exp_w.push_back(mk_w(m, b, b == beats - 1));
    endfunction

    // Slave-side monitor: pop and compare every accepted AW and W beat.
    always @(negedge clk) begin
        if (rst_n && s_awvalid && s_awready) begin
            total++;
            if (exp_aw.size() == 0) begin
                bad++;
                $display("FAIL aw_unexpected got=%h need=none", s_aw_pld);
            end else begin
                e_aw = exp_aw.pop_front();
                if (s_aw_pld !== e_aw) begin
                    bad++;
                    $display("FAIL aw_pld got=%h need=%h", s_aw_pld, e_aw);
                end
            end
        end
        if (rst_n && s_wvalid && s_wready) begin
            w_hs++;
            total++;
            if (exp_w.size() == 0) begin
                bad++;
                $display("FAIL w_unexpected got=%h need=none", s_w_pld);
            end else begin
                e_w = exp_w.pop_front();
                if (s_w_pld !== e_w) begin
                    bad++;
                    $display("FAIL w_pld got=%h need=%h", s_w_pld, e_w);
                end
            end
        end
    end

    task automatic aw_send(input int m, input logic [7:0] len);
        bit ok;
        ok = 1'b0;
        m_aw_pld[m*MAW +: MAW] = mk_aw(m, len);
        m_awvalid[m] = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (m_awready[m]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        m_awvalid[m] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL aw_handshake m=%0d got=timeout need=ready", m);
        end
    endtask

    task automatic w_beat(input int m, input int beat, input logic last);
        bit ok;
        ok = 1'b0;
        m_w_pld[m*WW +: WW] = mk_w(m, beat, last);
        m_wvalid[m] = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (m_wready[m]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        m_wvalid[m] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL w_handshake m=%0d beat=%0d got=timeout need=ready", m, beat);
        end
    endtask

    task automatic w_burst(input int m, input int beats);
        for (int b = 0; b < beats; b++) w_beat(m, b, b == beats - 1);
    endtask

    task automatic test_reset;
        m_awvalid = '1;
        m_wvalid  = '1;
        m_bready  = '1;
        s_bvalid  = 1'b1;
        #2;
        total++;
        if ({s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, s_bready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b_%b_%b_%b_%b need=all0",
                     s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, s_bready);
        end
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        s_bvalid  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_order;
        for (int m = 0; m < N; m++) push_aw(m, 8'd0);
        fork
            aw_send(0, 8'd0);
            aw_send(1, 8'd0);
            aw_send(2, 8'd0);
            aw_send(3, 8'd0);
        join
        for (int m = 0; m < N; m++) push_w(m, 1);
        fork
            w_burst(0, 1);
            w_burst(1, 1);
            w_burst(2, 1);
            w_burst(3, 1);
        join
        // Pointer wrapped to 0: master 0 must beat master 1.
        push_aw(0, 8'd0);
        push_aw(1, 8'd0);
        fork
            aw_send(1, 8'd0);
            aw_send(0, 8'd0);
        join
        push_w(0, 1);
        push_w(1, 1);
        w_burst(0, 1);
        w_burst(1, 1);
    endtask

    task automatic test_w_order;
        int base;
        push_aw(2, 8'd3);
        push_aw(0, 8'd0);
        aw_send(2, 8'd3);
        aw_send(0, 8'd0);
        push_w(2, 4);
        push_w(0, 1);
        base = w_hs;
        fork
            w_burst(2, 4);
            w_burst(0, 1);
            begin
                repeat (40) begin
                    @(negedge clk);
                    #1;
                    if (w_hs - base >= 5) break;
                    if (w_hs - base < 4) begin
                        total++;
                        if (m_wready[0] !== 1'b0) begin
                            bad++;
                            $display("FAIL w_hold_m0 got=%b need=0", m_wready[0]);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_fifo_full;
        for (int m = 0; m < N; m++) begin
            push_aw(m, 8'd0);
            aw_send(m, 8'd0);
        end
        push_aw(0, 8'd0);
        push_w(0, 1);
        fork
            aw_send(0, 8'd0);
            begin
                repeat (6) begin
                    @(negedge clk);
                    total++;
                    if (s_awvalid !== 1'b0 || m_awready !== '0) begin
                        bad++;
                        $display("FAIL full_block got=%b/%b need=0/0000", s_awvalid, m_awready);
                    end
                end
                @(posedge clk);
                #1;
                w_beat(0, 0, 1'b1);
            end
        join
        for (int m = 1; m < N; m++) begin
            push_w(m, 1);
            w_burst(m, 1);
        end
        push_w(0, 1);
        w_burst(0, 1);
    endtask

    task automatic test_b_route;
        s_b_pld  = {2'd1, 4'hA, 2'b10};
        s_bvalid = 1'b1;
        m_bready = 4'b0010;
        #1;
        total++;
        if (m_bvalid !== 4'b0010 || m_b_pld !== {4'hA, 2'b10} || s_bready !== 1'b1) begin
            bad++;
            $display("FAIL b_m1 got=%b/%b/%b need=0010/101010/1", m_bvalid, m_b_pld, s_bready);
        end
        m_bready = 4'b1101;
        #1;
        total++;
        if (s_bready !== 1'b0 || m_bvalid !== 4'b0010) begin
            bad++;
            $display("FAIL b_m1_stall got=%b/%b need=0/0010", s_bready, m_bvalid);
        end
        s_b_pld  = {2'd3, 4'h5, 2'b00};
        m_bready = 4'b1000;
        #1;
        total++;
        if (m_bvalid !== 4'b1000 || m_b_pld !== {4'h5, 2'b00} || s_bready !== 1'b1) begin
            bad++;
            $display("FAIL b_m3 got=%b/%b/%b need=1000/010100/1", m_bvalid, m_b_pld, s_bready);
        end
        s_bvalid = 1'b0;
        #1;
        total++;
        if (m_bvalid !== 4'b0000) begin
            bad++;
            $display("FAIL b_idle got=%b need=0000", m_bvalid);
        end
        m_bready = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_aw_stall;
        logic [SID_W+AWW-1:0] held;
        bit ok;
        s_awready = 1'b0;
        push_aw(1, 8'd0);
        push_aw(3, 8'd0);
        push_aw(0, 8'd0);
        fork
            aw_send(1, 8'd0);
            begin
                ok = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (s_awvalid) begin
                        ok = 1'b1;
                        break;
                    end
                end
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL stall_issue got=timeout need=s_awvalid");
                end
                held = s_aw_pld;
                @(posedge clk);
                #1;
                fork
                    aw_send(3, 8'd0);
                    aw_send(0, 8'd0);
                    begin
                        repeat (5) begin
                            @(negedge clk);
                            total++;
                            if (s_awvalid !== 1'b1 || s_aw_pld !== held || m_awready !== '0) begin
                                bad++;
                                $display("FAIL stall_hold got=%b/%h/%b need=1/%h/0000",
                                         s_awvalid, s_aw_pld, m_awready, held);
                            end
                        end
                        @(posedge clk);
                        #1;
                        s_awready = 1'b1;
                    end
                join
            end
        join
        push_w(1, 1);
        push_w(3, 1);
        push_w(0, 1);
        w_burst(1, 1);
        w_burst(3, 1);
        w_burst(0, 1);
    endtask

    task automatic test_reset_mid_burst;
        push_aw(2, 8'd3);
        aw_send(2, 8'd3);
        exp_w.push_back(mk_w(2, 0, 1'b0));
        exp_w.push_back(mk_w(2, 1, 1'b0));
        w_beat(2, 0, 1'b0);
        w_beat(2, 1, 1'b0);
        s_awready = 1'b0;
        s_wready  = 1'b0;
        m_aw_pld[1*MAW +: MAW] = mk_aw(1, 8'd0);
        m_awvalid[1] = 1'b1;
        m_w_pld[2*WW +: WW] = mk_w(2, 2, 1'b0);
        m_wvalid[2] = 1'b1;
        s_b_pld  = {2'd2, 4'h3, 2'b00};
        s_bvalid = 1'b1;
        m_bready = '1;
        @(posedge clk);
        @(posedge clk);
        #3;
        total++;
        if (s_awvalid !== 1'b1 || s_wvalid !== 1'b1 || m_bvalid !== 4'b0100) begin
            bad++;
            $display("FAIL pre_reset got=%b/%b/%b need=1/1/0100", s_awvalid, s_wvalid, m_bvalid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, s_bready} !== '0) begin
            bad++;
            $display("FAIL mid_reset got=%b%b_%b_%b_%b_%b need=all0",
                     s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, s_bready);
        end
        m_awvalid = '0;
        m_wvalid  = '0;
        s_bvalid  = 1'b0;
        m_bready  = '0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_aw(0, 8'd0);
        push_aw(3, 8'd0);
        fork
            aw_send(3, 8'd0);
            aw_send(0, 8'd0);
        join
        push_w(0, 1);
        push_w(3, 1);
        w_burst(0, 1);
        w_burst(3, 1);
    endtask

    initial begin
        m_aw_pld  = '0;
        m_awvalid = '0;
        m_w_pld   = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_b_pld   = '0;
        s_bvalid  = 1'b0;
        test_reset;
        test_rr_order;
        test_w_order;
        test_fifo_full;
        test_b_route;
        test_aw_stall;
        test_reset_mid_burst;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d need=0/0", exp_aw.size(), exp_w.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_rr_arbiter.md
Name: axi_wr_rr_arbiter

Overview:
Parametrised N-master to 1-slave AXI4 write-path arbiter. Arbitrates AW round-robin, routes W bursts in AW-acceptance order via an index FIFO, and returns B responses to the issuing master by prefixing the master index onto the slave-side ID. Sits between CPU/DMA masters and a single memory-mapped slave, as the write-path successor to the 2-master fixed-priority arbiter.

Parameters:
NUM_MASTERS, 4, number of master ports (2..16)
ADDR_WIDTH, 32, AW address width
DATA_WIDTH, 32, W data width (multiple of 8)
ID_WIDTH, 4, master-side ID width
W_FIFO_DEPTH, 4, max AW accepted ahead of W completion (power of 2, >=2)
Derived: IDX_W = max(1, clog2(NUM_MASTERS)); SID_W = ID_WIDTH+IDX_W; AW_W = ADDR_WIDTH+13; W_W = DATA_WIDTH+DATA_WIDTH/8+1

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
m_aw_pld  in  NUM_MASTERS*(ID_WIDTH+AW_W)  per master {awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0]}; master i at slice i
m_awvalid  in  NUM_MASTERS  AW valid per master
m_awready  out  NUM_MASTERS  AW ready per master
m_w_pld  in  NUM_MASTERS*W_W  per master {wdata, wstrb, wlast}
m_wvalid  in  NUM_MASTERS  W valid per master
m_wready  out  NUM_MASTERS  W ready per master
m_b_pld  out  ID_WIDTH+2  {bid, bresp}, broadcast to all masters
m_bvalid  out  NUM_MASTERS  B valid per master
m_bready  in  NUM_MASTERS  B ready per master
s_aw_pld  out  SID_W+AW_W  {awid = {idx, master awid}, awaddr, awlen, awsize, awburst}
s_awvalid  out  1  AW valid to slave
s_awready  in  1  AW ready from slave
s_w_pld  out  W_W  {wdata, wstrb, wlast}
s_wvalid  out  1  W valid to slave
s_wready  in  1  W ready from slave
s_b_pld  in  SID_W+2  {bid, bresp}
s_bvalid  in  1  B valid from slave
s_bready  out  1  B ready to slave

Behaviour:
- Reset (async, rst_n=0): AW FSM=IDLE, rr pointer=0, W FIFO empty. s_awvalid=0, s_wvalid=0, all m_awready=0, m_wready=0, m_bvalid=0; s_bready=0.
- AW FSM IDLE: if any m_awvalid and FIFO not full, pick first requester at or above pointer (wrapping); register sel, go ISSUE. No grant while FIFO full.
- AW FSM ISSUE: s_awvalid=1, s_aw_pld = slice[sel] with idx=sel prefixed to ID; m_awready[sel]=s_awready, others 0. On s_awvalid&s_awready: push sel into FIFO, pointer=(sel+1) mod NUM_MASTERS, go IDLE. Grant held until handshake; payload stable.
- AW latency: first s_awvalid 1 cycle after m_awvalid seen in IDLE; back-to-back AW minimum 2 cycles apart.
- W routing (combinational from FIFO head h): if FIFO non-empty, s_w_pld=slice[h], s_wvalid=m_wvalid[h], m_wready[h]=s_wready; all other m_wready=0. FIFO empty: s_wvalid=0, all m_wready=0 (W before AW waits).
- Pop on s_wvalid&s_wready&wlast. Push and pop in same cycle: occupancy unchanged. Full only blocks new AW grants.
- B routing (combinational): idx=s_bid[SID_W-1:ID_WIDTH]; m_bvalid[idx]=s_bvalid; s_bready=m_bready[idx]; m_b_pld={s_bid[ID_WIDTH-1:0], bresp}. idx>=NUM_MASTERS: s_bready=1, response dropped, no m_bvalid.
- Reset mid-burst: all state discarded; in-flight AW/W abandoned.

Test Plan:
- 4 masters assert AW together, awlen=0, slave always ready -> grants in order 0,1,2,3; s_awid upper bits 0..3; pointer returns to 0.
- Master 2 AW awlen=3 then master 0 AW awlen=0 -> s_w carries 4 beats from master 2 then 1 beat from master 0; m_wready[0]=0 until master 2 WLAST.
- 4 AWs accepted, W withheld, W_FIFO_DEPTH=4 -> 5th m_awvalid sees no grant; after one WLAST pop, 5th AW issues.
- s_bid={2'd1,4'hA}, bresp=2'b10 -> m_bvalid=4'b0010, m_b_pld={4'hA,2'b10}; s_bready follows m_bready[1].
- s_awready low 5 cycles in ISSUE, other masters request -> sel and s_aw_pld stable throughout; no grant change.
- rst_n pulsed low mid-burst -> all valid outputs 0 asynchronously; FIFO empty; next grant starts at master 0.
